// File: rtl/alu_control.sv
// Registered MIPS ALU operation decoder: ALUOp + funct -> ALUCtl with an illegal flag.
// Define ALUCTL_SHIFT_EN to decode the SLL/SRL/SRA funct codes; otherwise they are illegal.
module alu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] ALUCtl,
  output logic       illegal
);

  localparam logic [3:0] CtlAnd  = 4'b0000;
  localparam logic [3:0] CtlOr   = 4'b0001;
  localparam logic [3:0] CtlAdd  = 4'b0010;
  localparam logic [3:0] CtlXor  = 4'b0011;
  localparam logic [3:0] CtlSub  = 4'b0110;
  localparam logic [3:0] CtlSlt  = 4'b0111;
  localparam logic [3:0] CtlNor  = 4'b1100;
  localparam logic [3:0] CtlSltu = 4'b1111;
`ifdef ALUCTL_SHIFT_EN
  localparam logic [3:0] CtlSll  = 4'b1000;
  localparam logic [3:0] CtlSrl  = 4'b1001;
  localparam logic [3:0] CtlSra  = 4'b1010;
`endif

  logic [3:0] w_ctl;
  logic       w_illegal;
  logic [3:0] r_ctl;
  logic       r_illegal;

  // Unsupported combinations fall back to ADD so the ALU still sees a benign op.
  always_comb begin
    w_ctl     = CtlAdd;
    w_illegal = 1'b0;
    unique case (ALUOp)
      2'b00: w_ctl = CtlAdd;
      2'b01: w_ctl = CtlSub;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: w_ctl = CtlAdd;
          6'b100010, 6'b100011: w_ctl = CtlSub;
          6'b100100:            w_ctl = CtlAnd;
          6'b100101:            w_ctl = CtlOr;
          6'b100110:            w_ctl = CtlXor;
          6'b100111:            w_ctl = CtlNor;
          6'b101010:            w_ctl = CtlSlt;
          6'b101011:            w_ctl = CtlSltu;
`ifdef ALUCTL_SHIFT_EN
          6'b000000:            w_ctl = CtlSll;
          6'b000010:            w_ctl = CtlSrl;
          6'b000011:            w_ctl = CtlSra;
`endif
          default: begin
            w_ctl     = CtlAdd;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        w_ctl     = CtlAdd;
        w_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl     <= CtlAdd;
      r_illegal <= 1'b0;
    end else begin
      r_ctl     <= w_ctl;
      r_illegal <= w_illegal;
    end
  end

  assign ALUCtl  = r_ctl;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_control.sv
// Randomized self-checking bench for alu_control against a table-driven reference model.
// Honours ALUCTL_SHIFT_EN the same way the design does.
module tb_alu_control;

  logic       clk;
  logic       rst;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [3:0] ALUCtl;
  logic       illegal;

  int unsigned n_pass;
  int unsigned n_total;

  // Reference: R-type funct -> ALUCtl; absent entries are illegal.
  logic [3:0] rtype_tbl [int];
  logic [5:0] legal_functs [$];

  alu_control dut (
    .clk     (clk),
    .rst     (rst),
    .ALUOp   (ALUOp),
    .funct   (funct),
    .ALUCtl  (ALUCtl),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got illegal/ctl=%b_%b, expected %b_%b",
                  tag, got[4], got[3:0], exp[4], exp[3:0]);
  endtask

  function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 5'b0_0010;
    if (op == 2'd1) return 5'b0_0110;
    if (op == 2'd3) return 5'b1_0010;
    if (rtype_tbl.exists(int'(f))) return {1'b0, rtype_tbl[int'(f)]};
    return 5'b1_0010;
  endfunction

  // Apply inputs just after an edge, confirm outputs hold mid-cycle, then check after next edge.
  task automatic step(input logic r, input logic [1:0] op, input logic [5:0] f, input string tag);
    logic [4:0] prev;
    prev  = {illegal, ALUCtl};
    rst   = r;
    ALUOp = op;
    funct = f;
    #2;
    if ({illegal, ALUCtl} !== prev) check({tag, "_hold"}, {illegal, ALUCtl}, prev);
    @(posedge clk);
    #1;
    check(tag, {illegal, ALUCtl}, r ? 5'b0_0010 : model(op, f));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rtype_tbl[6'b100000] = 4'b0010;
    rtype_tbl[6'b100001] = 4'b0010;
    rtype_tbl[6'b100010] = 4'b0110;
    rtype_tbl[6'b100011] = 4'b0110;
    rtype_tbl[6'b100100] = 4'b0000;
    rtype_tbl[6'b100101] = 4'b0001;
    rtype_tbl[6'b100110] = 4'b0011;
    rtype_tbl[6'b100111] = 4'b1100;
    rtype_tbl[6'b101010] = 4'b0111;
    rtype_tbl[6'b101011] = 4'b1111;
`ifdef ALUCTL_SHIFT_EN
    rtype_tbl[6'b000000] = 4'b1000;
    rtype_tbl[6'b000010] = 4'b1001;
    rtype_tbl[6'b000011] = 4'b1010;
`endif
    legal_functs = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                     6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                     6'b000011};

    rst   = 1'b1;
    ALUOp = 2'b11;
    funct = 6'b111111;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("reset_hold", {illegal, ALUCtl}, 5'b0_0010);
    step(1'b1, 2'b10, 6'b100111, "reset_hold2");
    step(1'b0, 2'b01, 6'b000000, "post_reset_sub");

    step(1'b0, 2'b00, 6'b100000, "class_00");
    step(1'b0, 2'b01, 6'b100000, "class_01");
    step(1'b0, 2'b11, 6'b100000, "class_11");

    step(1'b0, 2'b10, 6'b100000, "r_add");
    step(1'b0, 2'b10, 6'b100010, "r_sub");
    step(1'b0, 2'b10, 6'b100100, "r_and");
    step(1'b0, 2'b10, 6'b100101, "r_or");
    step(1'b0, 2'b10, 6'b101010, "r_slt");
    step(1'b0, 2'b10, 6'b100110, "r_xor");
    step(1'b0, 2'b10, 6'b100111, "r_nor");
    step(1'b0, 2'b10, 6'b101011, "r_sltu");
    step(1'b0, 2'b10, 6'b100001, "r_addu");
    step(1'b0, 2'b10, 6'b100011, "r_subu");

    step(1'b0, 2'b10, 6'b000000, "shift_sll");
    step(1'b0, 2'b10, 6'b000010, "shift_srl");
    step(1'b0, 2'b10, 6'b000011, "shift_sra");

    step(1'b0, 2'b10, 6'b111111, "illegal_funct");
    step(1'b0, 2'b10, 6'b100101, "legal_after_illegal");

    step(1'b0, 2'b10, 6'b100100, "mid_a");
    step(1'b0, 2'b10, 6'b100111, "mid_b");
    step(1'b1, 2'b10, 6'b100100, "mid_rst");
    step(1'b0, 2'b10, 6'b100111, "mid_resume");
    step(1'b0, 2'b10, 6'b101011, "mid_resume2");

    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [1:0] op;
      logic [5:0] f;
      r  = ($urandom_range(0, 19) == 0);
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        f = legal_functs[$urandom_range(0, legal_functs.size() - 1)];
      else
        f = 6'($urandom);
      step(r, op, f, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
